// File: rtl/scoreboard_hazard_unit_pkg.sv
// Shared types for the hazard controller: E-stage forward selects and per-cause flags.
// Types only; no latency and no backpressure.
package scoreboard_hazard_unit_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  // raw_fwd flags any active forwarding path (D or E); the others mirror their stall/flush cause.
  typedef struct packed {
    logic raw_fwd;
    logic load_use;
    logic scoreboard;
    logic structural;
    logic mispredict;
  } hazard_cause_t;

endpackage

// File: rtl/scoreboard_hazard_unit_scoreboard_table.sv
// Per-register pending bits and in-flight counter for long ops; pend_eff is combinational.
// Set/clear take effect at the next edge; no backpressure, the caller gates set_vld.
module scoreboard_hazard_unit_scoreboard_table #(
  parameter int NUM_REGS        = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   set_vld,
  input  logic [$clog2(NUM_REGS)-1:0]            set_rd,
  input  logic                                   clr_vld,
  input  logic [$clog2(NUM_REGS)-1:0]            clr_rd,
  input  logic                                   flush,
  output logic [NUM_REGS-1:0]                    pending,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   inflight_cnt,
  output logic [NUM_REGS-1:0]                    pend_eff
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_REGS-1:0] pend_next;
  logic [CNT_W-1:0]    cnt_next;
  logic                dec;

  // A completing long op writes the regfile this cycle, so its dependents see it resolved now.
  always_comb begin
    pend_eff = pending;
    if (clr_vld) pend_eff[clr_rd] = 1'b0;
  end

  always_comb begin
    pend_next = pend_eff;
    if (set_vld) pend_next[set_rd] = 1'b1;
    pend_next[0] = 1'b0;
  end

  // A stray completion with nothing outstanding must not wrap the counter.
  assign dec = clr_vld && (inflight_cnt != '0);

  always_comb begin
    cnt_next = inflight_cnt;
    if (set_vld && !dec)      cnt_next = inflight_cnt + CNT_W'(1);
    else if (!set_vld && dec) cnt_next = inflight_cnt - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= '0;
      inflight_cnt <= '0;
    end else if (flush) begin
      pending      <= '0;
      inflight_cnt <= '0;
    end else begin
      pending      <= pend_next;
      inflight_cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Pipeline hazard controller: scoreboard/structural/load-use stalls, flush priority, forwarding, watchdog.
// Stall/flush/forward are combinational from tags; scoreboard and watchdog update at the next edge.
module scoreboard_hazard_unit
  import scoreboard_hazard_unit_pkg::*;
#(
  parameter int NUM_REGS        = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STALL_TIMEOUT   = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 valid_d,
  input  logic [$clog2(NUM_REGS)-1:0]          rs1_d,
  input  logic [$clog2(NUM_REGS)-1:0]          rs2_d,
  input  logic [$clog2(NUM_REGS)-1:0]          rd_d,
  input  logic                                 regwrite_d,
  input  logic                                 longop_d,
  input  logic [$clog2(NUM_REGS)-1:0]          rs1_e,
  input  logic [$clog2(NUM_REGS)-1:0]          rs2_e,
  input  logic [$clog2(NUM_REGS)-1:0]          rd_e,
  input  logic                                 regwrite_e,
  input  logic                                 load_e,
  input  logic [$clog2(NUM_REGS)-1:0]          rd_m,
  input  logic [$clog2(NUM_REGS)-1:0]          rd_w,
  input  logic                                 regwrite_m,
  input  logic                                 regwrite_w,
  input  logic                                 lop_done,
  input  logic [$clog2(NUM_REGS)-1:0]          lop_rd,
  input  logic                                 mispredict,
  input  logic                                 flushflag,
  output logic                                 stall_f,
  output logic                                 stall_d,
  output logic                                 flush_d,
  output logic                                 flush_e,
  output logic                                 flush_m,
  output logic                                 forwarda_d,
  output logic                                 forwardb_d,
  output logic [1:0]                           forwarda_e,
  output logic [1:0]                           forwardb_e,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] inflight_cnt,
  output logic [NUM_REGS-1:0]                  pending,
  output logic                                 stall_timeout,
  output hazard_cause_t                        cause
);

  localparam int REG_AW = $clog2(NUM_REGS);
  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int WD_W   = $clog2(STALL_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(STALL_TIMEOUT);

  logic [NUM_REGS-1:0] pend_eff;
  logic sb_stall, str_stall, lu_stall, any_stall, redirect, issue, long_issue;
  logic [WD_W-1:0] wd_cnt, wd_next;

  // x0 is hardwired, so a zero tag never creates a dependency.
  function automatic logic hit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  function automatic logic [1:0] fwd_e(input logic [REG_AW-1:0] rs,
                                       input logic [REG_AW-1:0] m_rd, input logic m_we,
                                       input logic [REG_AW-1:0] w_rd, input logic w_we);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (m_we && hit(rs, m_rd))      sel = FWD_M;
    else if (w_we && hit(rs, w_rd)) sel = FWD_W;
    return sel;
  endfunction

  assign sb_stall  = valid_d && (pend_eff[rs1_d] || pend_eff[rs2_d] || (regwrite_d && pend_eff[rd_d]));
  assign str_stall = valid_d && longop_d && (inflight_cnt == CNT_MAX) && !lop_done;
  assign lu_stall  = valid_d && load_e && regwrite_e && (hit(rd_e, rs1_d) || hit(rd_e, rs2_d));
  assign any_stall = sb_stall || str_stall || lu_stall;
  assign redirect  = flushflag || mispredict;

  always_comb begin
    stall_f = !redirect && any_stall;
    stall_d = !redirect && any_stall;
    flush_d = redirect;
    flush_e = any_stall || redirect;
    flush_m = flushflag;
  end

  assign issue      = valid_d && !stall_d && !flush_d;
  assign long_issue = issue && longop_d && regwrite_d && (rd_d != '0);

  scoreboard_hazard_unit_scoreboard_table #(
    .NUM_REGS        (NUM_REGS),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_scoreboard_table (
    .clk          (clk),
    .rst_n        (rst_n),
    .set_vld      (long_issue),
    .set_rd       (rd_d),
    .clr_vld      (lop_done),
    .clr_rd       (lop_rd),
    .flush        (flushflag),
    .pending      (pending),
    .inflight_cnt (inflight_cnt),
    .pend_eff     (pend_eff)
  );

  assign forwarda_e = fwd_e(rs1_e, rd_m, regwrite_m, rd_w, regwrite_w);
  assign forwardb_e = fwd_e(rs2_e, rd_m, regwrite_m, rd_w, regwrite_w);
  assign forwarda_d = regwrite_w && hit(rs1_d, rd_w);
  assign forwardb_d = regwrite_w && hit(rs2_d, rd_w);

  always_comb begin
    cause            = '0;
    cause.raw_fwd    = (forwarda_e != 2'b00) || (forwardb_e != 2'b00) || forwarda_d || forwardb_d;
    cause.load_use   = lu_stall;
    cause.scoreboard = sb_stall;
    cause.structural = str_stall;
    cause.mispredict = mispredict;
  end

  always_comb begin
    wd_next = '0;
    if (stall_d) wd_next = (wd_cnt == WD_MAX) ? WD_MAX : wd_cnt + WD_W'(1);
  end

  // Flag is registered off the next count, so it tracks wd_cnt == STALL_TIMEOUT exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt        <= '0;
      stall_timeout <= 1'b0;
    end else begin
      wd_cnt        <= wd_next;
      stall_timeout <= (wd_next == WD_MAX);
    end
  end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Directed scenarios plus randomized traffic checked against a rule-level model of the hazard unit.
module tb_scoreboard_hazard_unit;
  import scoreboard_hazard_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_d, regwrite_d, longop_d, regwrite_e, load_e, regwrite_m, regwrite_w;
  logic lop_done, mispredict, flushflag;
  logic [4:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, lop_rd;
  logic stall_f, stall_d, flush_d, flush_e, flush_m, forwarda_d, forwardb_d, stall_timeout;
  logic [1:0] forwarda_e, forwardb_e;
  logic [2:0] inflight_cnt;
  logic [31:0] pending;
  hazard_cause_t cause;

  scoreboard_hazard_unit #(.NUM_REGS(32), .MAX_OUTSTANDING(4), .STALL_TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .regwrite_d(regwrite_d), .longop_d(longop_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .regwrite_e(regwrite_e), .load_e(load_e), .rd_m(rd_m), .rd_w(rd_w), .regwrite_m(regwrite_m),
    .regwrite_w(regwrite_w), .lop_done(lop_done), .lop_rd(lop_rd), .mispredict(mispredict),
    .flushflag(flushflag), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .flush_e(flush_e), .flush_m(flush_m), .forwarda_d(forwarda_d), .forwardb_d(forwardb_d),
    .forwarda_e(forwarda_e), .forwardb_e(forwardb_e), .inflight_cnt(inflight_cnt),
    .pending(pending), .stall_timeout(stall_timeout), .cause(cause)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Model state: which registers await a long op, how many are outstanding, stall run length.
  bit m_pend[32];
  int m_cnt;
  int m_wd;
  bit e_stall, e_flush_d;
  logic [51:0] exp_v;
  wire  [51:0] obs = {stall_f, stall_d, flush_d, flush_e, flush_m, forwarda_d, forwardb_d,
                      forwarda_e, forwardb_e, inflight_cnt, pending, stall_timeout, cause};

  function automatic bit waits_on(int r);
    return (r != 0) && m_pend[r] && !(lop_done && int'(lop_rd) == r);
  endfunction

  function automatic logic [1:0] e_src(int rs);
    if (rs == 0) return 2'd0;
    if (regwrite_m && int'(rd_m) == rs) return 2'd2;
    if (regwrite_w && int'(rd_w) == rs) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit d_src(int rs);
    return (rs != 0) && regwrite_w && int'(rd_w) == rs;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_cnt = 0;
    m_wd = 0;
  endtask

  task automatic model_eval();
    bit sb, st, lu, fe, fad, fbd, raw;
    logic [1:0] fae, fbe;
    logic [31:0] pv;
    sb = valid_d && (waits_on(rs1_d) || waits_on(rs2_d) || (regwrite_d && waits_on(rd_d)));
    st = valid_d && longop_d && m_cnt == 4 && !lop_done;
    lu = valid_d && load_e && regwrite_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    e_flush_d = mispredict || flushflag;
    e_stall = !e_flush_d && (sb || st || lu);
    fe = sb || st || lu || e_flush_d;
    fae = e_src(rs1_e);
    fbe = e_src(rs2_e);
    fad = d_src(rs1_d);
    fbd = d_src(rs2_d);
    raw = (fae != 0) || (fbe != 0) || fad || fbd;
    for (int i = 0; i < 32; i++) pv[i] = m_pend[i];
    exp_v = {e_stall, e_stall, e_flush_d, fe, flushflag, fad, fbd, fae, fbe, 3'(m_cnt), pv,
             (m_wd == 64), raw, lu, sb, st, mispredict};
  endtask

  task automatic model_update();
    bit long_iss;
    long_iss = valid_d && !e_stall && !e_flush_d && longop_d && regwrite_d && rd_d != 0;
    m_wd = e_stall ? ((m_wd >= 64) ? 64 : m_wd + 1) : 0;
    if (flushflag) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      m_cnt = 0;
    end else begin
      if (lop_done) m_pend[lop_rd] = 1'b0;
      if (long_iss) m_pend[rd_d] = 1'b1;
      m_cnt = m_cnt + (long_iss ? 1 : 0) - ((lop_done && m_cnt > 0) ? 1 : 0);
    end
  endtask

  task automatic tick();
    model_eval();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {valid_d, regwrite_d, longop_d, regwrite_e, load_e, regwrite_m, regwrite_w} = '0;
    {lop_done, mispredict, flushflag} = '0;
    {rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w, lop_rd} = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    model_reset();
    #1;
    n_checks++;
    if (obs !== 52'h0) begin n_fail++; $display("FAIL reset_state: got %h want 0", obs); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_scoreboard_raw();
    idle();
    valid_d = 1; longop_d = 1; regwrite_d = 1; rd_d = 5;
    #1; n_checks++;
    if (stall_d !== 1'b0) begin n_fail++; $display("FAIL raw_issue: stall_d=%b want 0", stall_d); end
    tick();
    longop_d = 0; rs1_d = 5; rd_d = 6;
    for (int k = 0; k < 3; k++) begin
      #1; n_checks++;
      if (stall_d !== 1'b1 || pending[5] !== 1'b1)
        begin n_fail++; $display("FAIL raw_stall: stall_d=%b pend5=%b want 1 1", stall_d, pending[5]); end
      tick();
    end
    lop_done = 1; lop_rd = 5;
    #1; n_checks++;
    if (stall_d !== 1'b0) begin n_fail++; $display("FAIL raw_release: stall_d=%b want 0", stall_d); end
    tick();
    idle();
    #1; n_checks++;
    if (pending !== 32'h0 || inflight_cnt !== 3'd0)
      begin n_fail++; $display("FAIL raw_drain: pending=%h cnt=%0d want 0 0", pending, inflight_cnt); end
  endtask

  task automatic test_structural();
    idle();
    valid_d = 1; longop_d = 1; regwrite_d = 1;
    for (int r = 1; r <= 4; r++) begin
      rd_d = 5'(r);
      tick();
    end
    rd_d = 8;
    #1; n_checks++;
    if (stall_d !== 1'b1 || cause.structural !== 1'b1 || inflight_cnt !== 3'd4)
      begin n_fail++; $display("FAIL struct_stall: stall=%b str=%b cnt=%0d want 1 1 4", stall_d, cause.structural, inflight_cnt); end
    lop_done = 1; lop_rd = 1;
    #1; n_checks++;
    if (stall_d !== 1'b0) begin n_fail++; $display("FAIL struct_release: stall_d=%b want 0", stall_d); end
    tick();
    idle();
    #1; n_checks++;
    if (inflight_cnt !== 3'd4 || pending !== 32'h0000_011C)
      begin n_fail++; $display("FAIL struct_after: cnt=%0d pending=%h want 4 0000011c", inflight_cnt, pending); end
    flushflag = 1;
    tick();
    idle();
  endtask

  task automatic test_load_use();
    idle();
    valid_d = 1; load_e = 1; regwrite_e = 1; rd_e = 7; rs2_d = 7;
    #1; n_checks++;
    if ({stall_f, stall_d, flush_e} !== 3'b111)
      begin n_fail++; $display("FAIL load_use: got %b want 111", {stall_f, stall_d, flush_e}); end
    tick();
    rd_e = 0; rs2_d = 0;
    #1; n_checks++;
    if ({stall_f, stall_d, flush_e} !== 3'b000)
      begin n_fail++; $display("FAIL load_use_x0: got %b want 000", {stall_f, stall_d, flush_e}); end
    tick();
    idle();
  endtask

  task automatic test_forward();
    idle();
    rd_m = 3; rd_w = 3; regwrite_m = 1; regwrite_w = 1; rs1_e = 3; rs1_d = 3;
    #1; n_checks++;
    if (forwarda_e !== 2'b10 || forwarda_d !== 1'b1 || cause.raw_fwd !== 1'b1)
      begin n_fail++; $display("FAIL fwd_m_wins: fa_e=%b fa_d=%b want 10 1", forwarda_e, forwarda_d); end
    regwrite_m = 0;
    #1; n_checks++;
    if (forwarda_e !== 2'b01) begin n_fail++; $display("FAIL fwd_w: fa_e=%b want 01", forwarda_e); end
    regwrite_m = 1; rs1_e = 0; rs1_d = 0; rd_m = 0; rd_w = 0;
    #1; n_checks++;
    if (forwarda_e !== 2'b00 || forwarda_d !== 1'b0)
      begin n_fail++; $display("FAIL fwd_x0: fa_e=%b fa_d=%b want 00 0", forwarda_e, forwarda_d); end
    tick();
    idle();
  endtask

  task automatic test_mispredict();
    idle();
    valid_d = 1; longop_d = 1; regwrite_d = 1; rd_d = 5;
    tick();
    longop_d = 0; regwrite_d = 0; rs1_d = 5; mispredict = 1;
    #1; n_checks++;
    if ({stall_f, flush_d, flush_e, cause.scoreboard, cause.mispredict} !== 5'b01111)
      begin n_fail++; $display("FAIL mispredict_prio: got %b want 01111", {stall_f, flush_d, flush_e, cause.scoreboard, cause.mispredict}); end
    tick();
    idle(); flushflag = 1;
    tick();
    idle();
  endtask

  task automatic test_flush();
    idle();
    valid_d = 1; longop_d = 1; regwrite_d = 1; rd_d = 5;
    tick();
    rd_d = 8;
    tick();
    idle();
    #1; n_checks++;
    if (pending !== 32'h0000_0120 || inflight_cnt !== 3'd2)
      begin n_fail++; $display("FAIL flush_setup: pending=%h cnt=%0d want 00000120 2", pending, inflight_cnt); end
    flushflag = 1; lop_done = 1; lop_rd = 5;
    #1; n_checks++;
    if ({flush_d, flush_e, flush_m} !== 3'b111)
      begin n_fail++; $display("FAIL flush_outs: got %b want 111", {flush_d, flush_e, flush_m}); end
    tick();
    idle();
    #1; n_checks++;
    if (pending !== 32'h0 || inflight_cnt !== 3'd0)
      begin n_fail++; $display("FAIL flush_clear: pending=%h cnt=%0d want 0 0", pending, inflight_cnt); end
  endtask

  task automatic test_watchdog();
    idle();
    valid_d = 1; longop_d = 1; regwrite_d = 1; rd_d = 9;
    tick();
    longop_d = 0; regwrite_d = 0; rs1_d = 9;
    for (int k = 1; k <= 70; k++) begin
      #1; n_checks++;
      if (stall_timeout !== (k >= 65) || stall_d !== 1'b1)
        begin n_fail++; $display("FAIL watchdog cycle %0d: timeout=%b stall=%b want %b 1", k, stall_timeout, stall_d, (k >= 65)); end
      tick();
    end
    rst_n = 1'b0;
    model_reset();
    #1; n_checks++;
    if (obs !== 52'h0) begin n_fail++; $display("FAIL reset_mid_stall: got %h want 0", obs); end
    rst_n = 1'b1;
    idle();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      valid_d    = ($urandom_range(0, 9) < 8);
      longop_d   = ($urandom_range(0, 9) < 3);
      regwrite_d = ($urandom_range(0, 9) < 8);
      rs1_d = 5'($urandom_range(0, 7)); rs2_d = 5'($urandom_range(0, 7)); rd_d = 5'($urandom_range(0, 7));
      rs1_e = 5'($urandom_range(0, 7)); rs2_e = 5'($urandom_range(0, 7)); rd_e = 5'($urandom_range(0, 7));
      rd_m  = 5'($urandom_range(0, 7)); rd_w  = 5'($urandom_range(0, 7)); lop_rd = 5'($urandom_range(0, 7));
      regwrite_e = $urandom_range(0, 1); load_e = ($urandom_range(0, 3) == 0);
      regwrite_m = $urandom_range(0, 1); regwrite_w = $urandom_range(0, 1);
      lop_done   = ($urandom_range(0, 3) == 0);
      mispredict = ($urandom_range(0, 19) == 0);
      flushflag  = ($urandom_range(0, 31) == 0);
      #1;
      model_eval();
      n_checks++;
      if (obs !== exp_v) begin n_fail++; $display("FAIL random cycle %0d: got %h want %h", c, obs, exp_v); end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_scoreboard_raw();
    test_structural();
    test_load_use();
    test_forward();
    test_mispredict();
    test_flush();
    test_watchdog();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
